// File: rtl/circle_engine.sv
// circle_engine: midpoint-circle rasteriser feeding the VGA adapter's plot port.
// Emits one pixel per cycle (outline octants or filled spans), clips to the
// visible screen, and handshakes with the task controller through start/done.
// Optional filled-disc datapath is compiled in when CIRCLE_FILL_EN is defined;
// without it the fill input has no effect and every draw is an outline.

module circle_engine #(
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int RW       = 8,
   parameter int CW       = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] colour,
   input  logic [XW-1:0] centre_x,
   input  logic [YW-1:0] centre_y,
   input  logic [RW-1:0] radius,
   input  logic          fill,
   input  logic          start,
   output logic          done,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [CW-1:0] vga_colour,
   output logic          vga_plot
);

   // Signed pixel coordinate widths leave room for negative and past-edge values.
   localparam int PXW = XW + 2;
   localparam int PYW = YW + 2;
   // Offsets are signed so that ox may step to -1 after a radius-0 iteration.
   localparam int OW  = RW + 1;
   localparam int CRW = RW + 3;

   localparam logic signed [OW-1:0]  ONE_O = OW'(1);
   localparam logic signed [CRW-1:0] ONE_C = CRW'(1);

`ifdef CIRCLE_FILL_EN
   localparam bit FILL_BUILD = 1'b1;
`else
   localparam bit FILL_BUILD = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      OCT,
      SPAN,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   // Values latched at start so the controller may change its inputs mid-draw.
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [RW-1:0] rad;
   logic [CW-1:0] col;
   logic          fill_q;

   // Midpoint algorithm state.
   logic signed [OW-1:0]  ox;
   logic signed [OW-1:0]  oy;
   logic signed [CRW-1:0] crit;
   logic [2:0]            phase;

`ifdef CIRCLE_FILL_EN
   // Span walker: which of the four spans, and the current x offset within it.
   logic [1:0]           span;
   logic signed [OW-1:0] sx;
   logic signed [OW-1:0] span_half;
   logic signed [OW-1:0] next_half;
   logic                 span_end;
`endif

   // Combinational results for the current cycle.
   logic                  emit;
   logic                  last_in_iter;
   logic                  more;
   logic signed [OW-1:0]  dx;
   logic signed [OW-1:0]  dy;
   logic signed [OW-1:0]  ox_n;
   logic signed [OW-1:0]  oy_n;
   logic signed [CRW-1:0] crit_n;
   logic signed [PXW-1:0] px;
   logic signed [PYW-1:0] py;
   logic                  clip;

   // State register; reset returns to IDLE from anywhere.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, pixel offset selection, iteration update and screen clipping.
   always_comb begin
      next_state   = state;
      emit         = 1'b0;
      last_in_iter = 1'b0;
      dx           = '0;
      dy           = '0;
`ifdef CIRCLE_FILL_EN
      span_half    = span[1] ? oy : ox;
      next_half    = (span == 2'd0) ? ox : oy;
      span_end     = 1'b0;
`endif

      oy_n = oy + ONE_O;
      if (crit[CRW-1] || (crit == '0)) begin
         ox_n   = ox;
         crit_n = crit + (CRW'(oy_n) <<< 1) + ONE_C;
      end else begin
         ox_n   = ox - ONE_O;
         crit_n = crit + ((CRW'(oy_n) - CRW'(ox_n)) <<< 1) + ONE_C;
      end
      more = (oy_n <= ox_n);

      case (state)
         IDLE: begin
            if (start) begin
               next_state = INIT;
            end
         end
         INIT: begin
            next_state = (FILL_BUILD && fill_q) ? SPAN : OCT;
         end
         OCT: begin
            emit = 1'b1;
            case (phase)
               3'd0: begin dx =  ox; dy =  oy; end
               3'd1: begin dx =  oy; dy =  ox; end
               3'd2: begin dx = -oy; dy =  ox; end
               3'd3: begin dx = -ox; dy =  oy; end
               3'd4: begin dx = -ox; dy = -oy; end
               3'd5: begin dx = -oy; dy = -ox; end
               3'd6: begin dx =  oy; dy = -ox; end
               3'd7: begin dx =  ox; dy = -oy; end
            endcase
            last_in_iter = (phase == 3'd7);
         end
`ifdef CIRCLE_FILL_EN
         SPAN: begin
            emit = 1'b1;
            dx   = sx;
            case (span)
               2'd0: dy =  oy;
               2'd1: dy = -oy;
               2'd2: dy =  ox;
               2'd3: dy = -ox;
            endcase
            span_end     = (sx == span_half);
            last_in_iter = span_end && (span == 2'd3);
         end
`endif
         DONE: begin
            if (!start) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      if (last_in_iter && !more) begin
         next_state = DONE;
      end

      px   = signed'(PXW'(cx)) + PXW'(dx);
      py   = signed'(PYW'(cy)) + PYW'(dy);
      clip = px[PXW-1] || (px >= signed'(PXW'(SCREEN_W))) ||
             py[PYW-1] || (py >= signed'(PYW'(SCREEN_H)));
   end

   // Datapath: input latching, algorithm registers and registered VGA outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done       <= 1'b0;
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         cx         <= '0;
         cy         <= '0;
         rad        <= '0;
         col        <= '0;
         fill_q     <= 1'b0;
         ox         <= '0;
         oy         <= '0;
         crit       <= '0;
         phase      <= '0;
`ifdef CIRCLE_FILL_EN
         span       <= '0;
         sx         <= '0;
`endif
      end else begin
         done <= (state == DONE);

         if (emit && !clip) begin
            vga_plot   <= 1'b1;
            vga_x      <= px[XW-1:0];
            vga_y      <= py[YW-1:0];
            vga_colour <= col;
         end else begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  cx     <= centre_x;
                  cy     <= centre_y;
                  rad    <= radius;
                  col    <= colour;
                  fill_q <= fill;
               end
            end
            INIT: begin
               ox    <= signed'(OW'(rad));
               oy    <= '0;
               crit  <= ONE_C - signed'(CRW'(rad));
               phase <= '0;
`ifdef CIRCLE_FILL_EN
               span  <= '0;
               sx    <= -signed'(OW'(rad));
`endif
            end
            OCT: begin
               phase <= phase + 3'd1;
               if (last_in_iter) begin
                  oy   <= oy_n;
                  ox   <= ox_n;
                  crit <= crit_n;
               end
            end
`ifdef CIRCLE_FILL_EN
            SPAN: begin
               if (span_end) begin
                  span <= span + 2'd1;
                  if (span == 2'd3) begin
                     oy   <= oy_n;
                     ox   <= ox_n;
                     crit <= crit_n;
                     sx   <= -ox_n;
                  end else begin
                     sx <= -next_half;
                  end
               end else begin
                  sx <= sx + ONE_O;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_circle_engine.sv
// tb_circle_engine: self-checking bench for circle_engine. A behavioural model
// walks the midpoint recurrence with plain integers, lists every pixel cycle
// (clipped ones included) and the bench compares each cycle of the DUT to it.

module tb_circle_engine;

   localparam int XW = 8;
   localparam int YW = 7;
   localparam int RW = 8;
   localparam int CW = 3;
   localparam int SW = 160;
   localparam int SH = 120;

`ifdef CIRCLE_FILL_EN
   localparam bit FILL_ON = 1'b1;
`else
   localparam bit FILL_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] colour = '0;
   logic [XW-1:0] centre_x = '0;
   logic [YW-1:0] centre_y = '0;
   logic [RW-1:0] radius = '0;
   logic          fill = 1'b0;
   logic          start = 1'b0;
   logic          done;
   logic [XW-1:0] vga_x;
   logic [YW-1:0] vga_y;
   logic [CW-1:0] vga_colour;
   logic          vga_plot;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   circle_engine #(
      .XW(XW), .YW(YW), .RW(RW), .CW(CW), .SCREEN_W(SW), .SCREEN_H(SH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .colour(colour),
      .centre_x(centre_x),
      .centre_y(centre_y),
      .radius(radius),
      .fill(fill),
      .start(start),
      .done(done),
      .vga_x(vga_x),
      .vga_y(vga_y),
      .vga_colour(vga_colour),
      .vga_plot(vga_plot)
   );

   typedef struct {
      bit plot;
      int x;
      int y;
   } pix_t;

   pix_t expQ[$];
   int   checkCount = 0;
   int   passCount = 0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d at time %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic pushPix(input int x, input int y);
      pix_t p;
      if (x < 0 || x >= SW || y < 0 || y >= SH) begin
         p.plot = 1'b0; p.x = 0; p.y = 0;
      end else begin
         p.plot = 1'b1; p.x = x; p.y = y;
      end
      expQ.push_back(p);
   endtask

   task automatic pushSpan(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) begin
         pushPix(x, y);
      end
   endtask

   task automatic buildModel(input int cx, input int cy, input int r, input bit f);
      int ox;
      int oy;
      int crit;
      expQ.delete();
      ox = r;
      oy = 0;
      crit = 1 - r;
      do begin
         if (f) begin
            pushSpan(cy + oy, cx - ox, cx + ox);
            pushSpan(cy - oy, cx - ox, cx + ox);
            pushSpan(cy + ox, cx - oy, cx + oy);
            pushSpan(cy - ox, cx - oy, cx + oy);
         end else begin
            pushPix(cx + ox, cy + oy);
            pushPix(cx + oy, cy + ox);
            pushPix(cx - oy, cy + ox);
            pushPix(cx - ox, cy + oy);
            pushPix(cx - ox, cy - oy);
            pushPix(cx - oy, cy - ox);
            pushPix(cx + oy, cy - ox);
            pushPix(cx + ox, cy - oy);
         end
         oy = oy + 1;
         if (crit <= 0) begin
            crit = crit + 2 * oy + 1;
         end else begin
            ox = ox - 1;
            crit = crit + 2 * (oy - ox) + 1;
         end
      end while (oy <= ox);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checkOutput("idle_plot", int'(vga_plot), 0);
         checkOutput("idle_done", int'(done), 0);
      end
   endtask

   // One complete draw: request, per-cycle pixel comparison, done handshake.
   // Returns just after the edge that samples start low in DONE.
   task automatic applyStimulus(input int cx, input int cy, input int r, input bit f,
                                input int col, input bit dropStart, input int holdCycles);
      pix_t e;
      int   dropAt;
      buildModel(cx, cy, r, f && FILL_ON);
      centre_x = cx[XW-1:0];
      centre_y = cy[YW-1:0];
      radius   = r[RW-1:0];
      colour   = col[CW-1:0];
      fill     = f;
      start    = 1'b1;
      @(posedge clk); #1;
      checkOutput("init_plot", int'(vga_plot), 0);
      checkOutput("init_done", int'(done), 0);
      centre_x = XW'($urandom);
      centre_y = YW'($urandom);
      radius   = RW'($urandom);
      colour   = CW'($urandom);
      fill     = ~f;
      @(posedge clk); #1;
      checkOutput("init2_plot", int'(vga_plot), 0);
      dropAt = dropStart ? int'($urandom_range(0, expQ.size() - 1)) : -1;
      for (int k = 0; k < expQ.size(); k++) begin
         if (k == dropAt) start = 1'b0;
         @(posedge clk); #1;
         e = expQ[k];
         checkOutput("pix_plot", int'(vga_plot), int'(e.plot));
         if (e.plot) begin
            checkOutput("pix_x", int'(vga_x), e.x);
            checkOutput("pix_y", int'(vga_y), e.y);
            checkOutput("pix_colour", int'(vga_colour), col);
         end
         checkOutput("busy_done", int'(done), 0);
      end
      @(posedge clk); #1;
      checkOutput("done_rise", int'(done), 1);
      checkOutput("done_plot", int'(vga_plot), 0);
      if (!dropStart) begin
         for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk); #1;
            checkOutput("done_hold", int'(done), 1);
         end
         start = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // Directed scenarios, mid-draw reset, then randomized draws.
   initial begin
      int  rcx;
      int  rcy;
      int  rr;
      bit  rf;

      rst_n = 1'b0;
      start = 1'b1;
      radius = 8'd3;
      centre_x = 8'd80;
      centre_y = 7'd60;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checkOutput("rst_plot", int'(vga_plot), 0);
         checkOutput("rst_done", int'(done), 0);
         checkOutput("rst_x", int'(vga_x), 0);
         checkOutput("rst_y", int'(vga_y), 0);
         checkOutput("rst_colour", int'(vga_colour), 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      idleCycles(2);

      applyStimulus(80, 60, 0, 1'b0, 5, 1'b0, 2);
      idleCycles(1);
      applyStimulus(80, 60, 1, 1'b0, 3, 1'b0, 0);
      applyStimulus(0, 0, 5, 1'b0, 7, 1'b1, 0);
      applyStimulus(80, 60, 5, 1'b0, 6, 1'b0, 1);
      applyStimulus(80, 60, 1, 1'b1, 2, 1'b0, 1);
      applyStimulus(80, 60, 0, 1'b1, 4, 1'b0, 0);
      applyStimulus(159, 119, 3, 1'b1, 1, 1'b1, 0);
      idleCycles(1);

      centre_x = 8'd80;
      centre_y = 7'd60;
      radius   = 8'd40;
      colour   = 3'd5;
      fill     = 1'b0;
      start    = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
      end
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_plot", int'(vga_plot), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_x", int'(vga_x), 0);
      rst_n = 1'b1;
      idleCycles(3);
      applyStimulus(80, 60, 7, 1'b0, 3, 1'b0, 0);

      for (int n = 0; n < 16; n++) begin
         rf  = 1'($urandom_range(0, 1));
         rr  = rf ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 24));
         rcx = int'($urandom_range(0, 255));
         rcy = int'($urandom_range(0, 127));
         applyStimulus(rcx, rcy, rr, rf, int'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         if ($urandom_range(0, 1) == 1) idleCycles(1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
